// File: rtl/faccumulator.sv
// FP32 dot-product accumulator: sums a stream of products using a four-step
// align/add/normalise sequence, with round toward zero and a sticky exception flag.
module faccumulator #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_exception,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_exception,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StDone} state_e;

    state_e state_q, state_d;

    logic [31:0]      acc_q, acc_d;
    logic             exc_q, exc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      term_q, term_d;
    logic             last_q, last_d;
    logic             bad_q, bad_d;
    logic [23:0]      big_sig_q, big_sig_d;
    logic [23:0]      small_sig_q, small_sig_d;
    logic [7:0]       exp_q, exp_d;
    logic             big_sign_q, big_sign_d;
    logic             small_sign_q, small_sign_d;
    logic [24:0]      sum_q, sum_d;
    logic             sum_sign_q, sum_sign_d;

    logic [7:0]  acc_e, term_e, diff;
    logic [23:0] acc_m, term_m, small_m, small_al;
    logic        acc_big;
    logic [4:0]  lz;
    logic [23:0] norm_sig;
    logic [31:0] norm_res;
    logic        norm_ovf;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd24;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(23 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StAlign;
            StAlign: state_d = StAdd;
            StAdd:   state_d = StNorm;
            StNorm:  state_d = last_q ? StDone : StIdle;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready      = (state_q == StIdle) && !reset;
        out_valid     = (state_q == StDone) && !reset;
        out_data      = acc_q;
        out_exception = exc_q;
        out_count     = cnt_q;
    end

    // Operand decode; denormals (exponent 0) collapse to a zero significand.
    assign acc_e    = acc_q[30:23];
    assign term_e   = term_q[30:23];
    assign acc_m    = (acc_e == 8'd0) ? 24'd0 : {1'b1, acc_q[22:0]};
    assign term_m   = (term_e == 8'd0) ? 24'd0 : {1'b1, term_q[22:0]};
    assign acc_big  = (acc_e >= term_e);
    assign diff     = acc_big ? (acc_e - term_e) : (term_e - acc_e);
    assign small_m  = acc_big ? term_m : acc_m;
    assign small_al = (diff >= 8'd26) ? 24'd0 : (small_m >> diff);

    // Renormalisation of the registered sum, truncating (round toward zero).
    assign lz       = lzc24(sum_q[23:0]);
    assign norm_sig = sum_q[23:0] << lz;

    always_comb begin
        norm_res = 32'h0000_0000;
        norm_ovf = 1'b0;
        if (sum_q == 25'd0) begin
            norm_res = 32'h0000_0000;
        end else if (sum_q[24]) begin
            if (exp_q >= 8'd254) begin
                norm_res = {sum_sign_q, 8'hFF, 23'd0};
                norm_ovf = 1'b1;
            end else begin
                norm_res = {sum_sign_q, exp_q + 8'd1, sum_q[23:1]};
            end
        end else if ({3'b000, lz} >= exp_q) begin
            norm_res = 32'h0000_0000;
        end else begin
            norm_res = {sum_sign_q, exp_q - {3'b000, lz}, norm_sig[22:0]};
        end
    end

    always_comb begin
        acc_d        = acc_q;
        exc_d        = exc_q;
        cnt_d        = cnt_q;
        term_d       = term_q;
        last_d       = last_q;
        bad_d        = bad_q;
        big_sig_d    = big_sig_q;
        small_sig_d  = small_sig_q;
        exp_d        = exp_q;
        big_sign_d   = big_sign_q;
        small_sign_d = small_sign_q;
        sum_d        = sum_q;
        sum_sign_d   = sum_sign_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    term_d = in_data;
                    last_d = in_last;
                    bad_d  = in_exception || (in_data[30:23] == 8'hFF);
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StAlign: begin
                big_sig_d    = acc_big ? acc_m : term_m;
                small_sig_d  = small_al;
                exp_d        = acc_big ? acc_e : term_e;
                big_sign_d   = acc_big ? acc_q[31] : term_q[31];
                small_sign_d = acc_big ? term_q[31] : acc_q[31];
            end
            StAdd: begin
                if (big_sign_q == small_sign_q) begin
                    sum_d      = {1'b0, big_sig_q} + {1'b0, small_sig_q};
                    sum_sign_d = big_sign_q;
                end else if (big_sig_q >= small_sig_q) begin
                    sum_d      = {1'b0, big_sig_q - small_sig_q};
                    sum_sign_d = big_sign_q;
                end else begin
                    sum_d      = {1'b0, small_sig_q - big_sig_q};
                    sum_sign_d = small_sign_q;
                end
            end
            StNorm: begin
                // Once flagged, the accumulator holds its NaN/Inf until cleared.
                if (bad_q) begin
                    acc_d = 32'h7FC0_0000;
                    exc_d = 1'b1;
                end else if (!exc_q) begin
                    acc_d = norm_res;
                    exc_d = norm_ovf;
                end
            end
            StDone: begin
                if (out_ready) begin
                    acc_d = 32'h0000_0000;
                    exc_d = 1'b0;
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= 32'h0000_0000;
            exc_q        <= 1'b0;
            cnt_q        <= '0;
            term_q       <= 32'h0000_0000;
            last_q       <= 1'b0;
            bad_q        <= 1'b0;
            big_sig_q    <= 24'd0;
            small_sig_q  <= 24'd0;
            exp_q        <= 8'd0;
            big_sign_q   <= 1'b0;
            small_sign_q <= 1'b0;
            sum_q        <= 25'd0;
            sum_sign_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            exc_q        <= exc_d;
            cnt_q        <= cnt_d;
            term_q       <= term_d;
            last_q       <= last_d;
            bad_q        <= bad_d;
            big_sig_q    <= big_sig_d;
            small_sig_q  <= small_sig_d;
            exp_q        <= exp_d;
            big_sign_q   <= big_sign_d;
            small_sign_q <= small_sign_d;
            sum_q        <= sum_d;
            sum_sign_q   <= sum_sign_d;
        end
    end

endmodule

// File: tb/tb_faccumulator.sv
// Bench for faccumulator: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_faccumulator;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_exception;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_exception;
    logic [CW-1:0] out_count;

    faccumulator #(.CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_exception  (in_exception),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_exception (out_exception),
        .out_count     (out_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: value = sig * 2^exp, aligned with truncation,
    // summed as signed integers, then renormalised by repeated shifting.
    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b,
                                          output bit ovf);
        int     ea, eb, e, d;
        longint ma, mb, va, vb, s, m;
        bit     sg;
        ovf = 1'b0;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        ma  = (ea == 0) ? 64'sd0 : longint'({1'b1, a[22:0]});
        mb  = (eb == 0) ? 64'sd0 : longint'({1'b1, b[22:0]});
        if (ea >= eb) begin
            e  = ea;
            d  = ea - eb;
            mb = (d >= 26) ? 64'sd0 : (mb >> d);
        end else begin
            e  = eb;
            d  = eb - ea;
            ma = (d >= 26) ? 64'sd0 : (ma >> d);
        end
        va = a[31] ? -ma : ma;
        vb = b[31] ? -mb : mb;
        s  = va + vb;
        if (s == 0) return 32'h0000_0000;
        sg = (s < 0);
        m  = sg ? -s : s;
        while (m >= (64'sd1 <<< 24)) begin m = m >>> 1; e++; end
        while (m < (64'sd1 <<< 23)) begin m = m <<< 1; e--; end
        if (e <= 0) return 32'h0000_0000;
        if (e >= 255) begin
            ovf = 1'b1;
            return {sg, 8'hFF, 23'd0};
        end
        return {sg, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] m_sum(input logic [31:0] a, input logic [31:0] b);
        bit o;
        return m_add(a, b, o);
    endfunction

    function automatic bit m_ovf(input logic [31:0] a, input logic [31:0] b);
        bit          o;
        logic [31:0] r;
        r = m_add(a, b, o);
        return o;
    endfunction

    // Transaction-level model: a term is busy for three edges after acceptance.
    int          busy  = 0;
    bit          mdone = 1'b0;
    logic [31:0] macc  = 32'h0;
    bit          mexc  = 1'b0;
    int          mcnt  = 0;
    logic [31:0] pdata = 32'h0;
    bit          pbad  = 1'b0;
    bit          plast = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            busy <= 0; mdone <= 1'b0; macc <= 32'h0; mexc <= 1'b0; mcnt <= 0;
        end else if (mdone) begin
            if (out_ready) begin
                mdone <= 1'b0; macc <= 32'h0; mexc <= 1'b0; mcnt <= 0;
            end
        end else if (busy > 0) begin
            busy <= busy - 1;
            if (busy == 1) begin
                if (pbad) begin
                    macc <= 32'h7FC0_0000;
                    mexc <= 1'b1;
                end else if (!mexc) begin
                    macc <= m_sum(macc, pdata);
                    mexc <= m_ovf(macc, pdata);
                end
                if (plast) mdone <= 1'b1;
            end
        end else if (in_valid) begin
            pdata <= in_data;
            pbad  <= in_exception || (in_data[30:23] == 8'hFF);
            plast <= in_last;
            busy  <= 3;
            if (mcnt < (1 << CW) - 1) mcnt <= mcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !reset && busy == 0 && !mdone});
            chk("out_valid", {31'd0, out_valid}, {31'd0, !reset && mdone});
            if (mdone && !reset) begin
                chk("out_data", out_data, macc);
                chk("out_exception", {31'd0, out_exception}, {31'd0, mexc});
                chk("out_count", 32'(out_count), mcnt);
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit e, input bit l);
        bit ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (in_ready) begin
                in_valid = 1'b1; in_data = d; in_exception = e; in_last = l;
                ok = 1'b1;
                @(posedge clk);
                #1;
                in_valid = 1'b0; in_exception = 1'b0; in_last = 1'b0;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string name, input logic [31:0] d, input bit e,
                             input int c);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        chk({name, "_valid"}, {31'd0, got}, 32'd1);
        chk({name, "_data"}, out_data, d);
        chk({name, "_exc"}, {31'd0, out_exception}, {31'd0, e});
        chk({name, "_count"}, 32'(out_count), c);
    endtask

    task automatic ack();
        @(negedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_term();
        int         r;
        logic [7:0] e;
        r = $urandom_range(0, 99);
        if (r < 70)      e = 8'($urandom_range(120, 134));
        else if (r < 80) e = 8'($urandom_range(250, 254));
        else if (r < 85) e = 8'd0;
        else if (r < 90) e = 8'hFF;
        else if (r < 95) e = 8'($urandom_range(1, 4));
        else             e = 8'($urandom);
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_exception = 1'b0;
        in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_chk = 1'b1;

        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_exc", {31'd0, out_exception}, 32'd0);
        chk("rst_data", out_data, 32'h0);

        // 1 + 2, then backpressure with ignored in_valid pulses
        send(32'h3F80_0000, 1'b0, 1'b0);
        send(32'h4000_0000, 1'b0, 1'b1);
        wait_done("sum3", 32'h4040_0000, 1'b0, 2);
        for (int i = 0; i < 5; i++) begin
            #1 in_valid = (i % 2 == 0); in_data = 32'h3F80_0000;
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", out_data, 32'h4040_0000);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
        end
        #1 in_valid = 1'b0;
        chk("hold_count", 32'(out_count), 32'd2);
        ack();

        send(32'h3FC0_0000, 1'b0, 1'b0);
        send(32'h4020_0000, 1'b0, 1'b1);
        wait_done("sum4", 32'h4080_0000, 1'b0, 2);
        ack();
        send(32'h3F80_0000, 1'b0, 1'b0);
        send(32'hBF80_0000, 1'b0, 1'b1);
        wait_done("cancel", 32'h0000_0000, 1'b0, 2);
        ack();

        send(32'h7F7F_FFFF, 1'b0, 1'b0);
        send(32'h7F7F_FFFF, 1'b0, 1'b1);
        wait_done("ovf", 32'h7F80_0000, 1'b1, 2);
        ack();

        send(32'h4000_0000, 1'b1, 1'b0);
        send(32'h3F80_0000, 1'b0, 1'b1);
        wait_done("nan", 32'h7FC0_0000, 1'b1, 2);
        ack();

        // Reset while the second term is in ADD
        send(32'h3F80_0000, 1'b0, 1'b0);
        send(32'h4000_0000, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_count", 32'(out_count), 32'd0);
        send(32'h3F80_0000, 1'b0, 1'b1);
        wait_done("midrst", 32'h3F80_0000, 1'b0, 1);
        ack();

        // 17 ones: count saturates at 15, sum is 17.0
        for (int i = 0; i < 17; i++) send(32'h3F80_0000, 1'b0, i == 16);
        wait_done("sat", 32'h4188_0000, 1'b0, 15);
        ack();

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            #1;
            reset        = ($urandom_range(0, 299) == 0);
            in_valid     = 1'($urandom);
            in_data      = rand_term();
            in_exception = ($urandom_range(0, 49) == 0);
            in_last      = ($urandom_range(0, 4) == 0);
            out_ready    = 1'($urandom);
        end
        @(negedge clk);
        #1 reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/faccumulator.md
FACCUMULATOR -- requirements
Module: faccumulator

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the term counter.
REQ-002 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, an FP32 product is presented on in_data.
REQ-005 SHALL have port in_ready, output, 1, block accepts a term this cycle.
REQ-006 SHALL have port in_data, input, 32, IEEE-754 single-precision product from the upstream Fmultiplier result.
REQ-007 SHALL have port in_exception, input, 1, the upstream multiplier exception flag, qualified by in_valid.
REQ-008 SHALL have port in_last, input, 1, final term of the current dot product, qualified by in_valid.
REQ-009 SHALL have port out_valid, output, 1, accumulated sum is available.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the sum.
REQ-011 SHALL have port out_data, output, 32, FP32 accumulated sum.
REQ-012 SHALL have port out_exception, output, 1, sticky exception for the current sum.
REQ-013 SHALL have port out_count, output, CNT_W, number of terms accepted into the current sum.

Function
REQ-014 SHALL implement the FSM states IDLE, ALIGN, ADD, NORM and DONE.
REQ-015 SHALL drive in_ready high only in IDLE; a term is accepted when in_valid and in_ready are both high on a rising edge.
REQ-016 SHALL, on accept, move IDLE->ALIGN->ADD->NORM over the following edges, then go to IDLE, or to DONE if the accepted term had in_last=1; a term accepted at edge k re-raises in_ready after edge k+3.
REQ-017 SHALL, in ALIGN, right-shift the smaller-exponent 24-bit significand by the exponent difference, saturating at 26 or more bits to zero, and truncate the bits shifted out.
REQ-018 SHALL, in ADD, add or subtract the aligned significands by sign and take the result sign from the larger magnitude.
REQ-019 SHALL, in NORM, renormalise in a single cycle using a leading-zero count, with round toward zero.
REQ-020 SHALL flush denormal inputs to signed zero.
REQ-021 SHALL force an exact-zero result to +0 (32'h00000000).
REQ-022 SHALL flush exponent underflow to +0.
REQ-023 SHALL, on exponent overflow, set the accumulator to signed infinity (7F800000/FF800000) and set the sticky exception.
REQ-024 SHALL, when an accepted term has in_exception=1 or is Inf/NaN, set the sticky exception, force the accumulator to 32'h7FC00000, and keep it there until the sum is cleared.
REQ-025 SHALL increment out_count on every accept, saturating at 2^CNT_W-1.
REQ-026 SHALL, in DONE, hold out_valid=1 with out_data, out_exception and out_count stable until out_ready=1.
REQ-027 SHALL, on the DONE handshake edge, clear the accumulator to +0, clear the exception and count, and return to IDLE.
REQ-028 SHALL keep in_ready low in DONE (backpressure).
REQ-029 SHALL hold out_valid low outside DONE, and SHALL ignore out_ready outside DONE.
REQ-030 SHALL ignore in_valid when in_ready is low; a term presented then SHALL be neither accepted nor counted.
REQ-031 SHALL drive out_data with the live accumulator value, observable and valid only while out_valid is high.

Reset
REQ-032 SHALL, when reset is high on a rising edge, go to IDLE, with accumulator=32'h00000000, out_valid=0, out_exception=0, out_count=0, and in_ready=1 on the following cycle.
REQ-033 SHALL give reset priority over every other event; reset mid-operation (ALIGN, ADD, NORM or DONE) SHALL discard the partial sum and any pending output.
REQ-034 SHALL keep in_ready and out_valid low while reset is high.

Verification
REQ-035 SHALL be covered by scenario: accept 3F800000, then 40000000 with in_last -> out_valid=1, out_data=40400000, out_count=2, out_exception=0.
REQ-036 SHALL be covered by scenario: accept 3FC00000, 40200000 (last) -> 40800000; then 3F800000, BF800000 (last) -> 00000000, proving the clear between sums.
REQ-037 SHALL be covered by scenario: accept 7F7FFFFF twice (last) -> out_data=7F800000, out_exception=1.
REQ-038 SHALL be covered by scenario: accept 40000000 with in_exception=1, then 3F800000 (last) -> out_data=7FC00000, out_exception=1.
REQ-039 SHALL be covered by scenario: hold out_ready low 5 cycles in DONE -> out_valid and out_data stable and in_ready=0 throughout; in_valid pulses in that window are not counted.
REQ-040 SHALL be covered by scenario: assert reset in the ADD state after 2 terms -> next cycle in_ready=1, out_count=0, and the following 3F800000 (last) sums to 3F800000.
